// File: rtl/fa_multicycle.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock with the carry held
// in a register between chunks, behind valid/ready handshakes on both sides.
module fa_multicycle #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] beff_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] s_r;
  logic             co_r;
  logic             ovf_r;
  logic             out_valid_r;

  logic [CHUNK:0]   chunk_sum_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             ovf_s;

  assign in_ready  = (state_r == IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign co        = co_r;
  assign ovf       = ovf_r;

  // One chunk of the ripple add, merged into the accumulator; overflow judged on the full word
  always_comb begin
    chunk_sum_s = {1'b0, a_r[int'(cnt_r)*CHUNK +: CHUNK]}
                + {1'b0, beff_r[int'(cnt_r)*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry_r};
    acc_next_s = acc_r;
    acc_next_s[int'(cnt_r)*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
    ovf_s = (a_r[WIDTH-1] == beff_r[WIDTH-1]) && (acc_next_s[WIDTH-1] != a_r[WIDTH-1]);
  end

  // Control FSM with operand capture, chunk sequencing and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      beff_r      <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      s_r         <= {WIDTH{1'b0}};
      co_r        <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            beff_r  <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : ci;
            cnt_r   <= {CW{1'b0}};
            state_r <= CALC;
          end
        end
        CALC: begin
          acc_r   <= acc_next_s;
          carry_r <= chunk_sum_s[CHUNK];
          if (cnt_r == LAST_CNT) begin
            s_r         <= acc_next_s;
            co_r        <= chunk_sum_s[CHUNK];
            ovf_r       <= ovf_s;
            out_valid_r <= 1'b1;
            cnt_r       <= {CW{1'b0}};
            state_r     <= DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here: no accept on the result-handshake cycle
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_multicycle.sv
// Directed bench for fa_multicycle: a vector table run through a 4-bit-chunk and a
// single-chunk instance, plus backpressure and mid-operation reset sequences.
module tb_fa_multicycle;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = 16'h0000, b = 16'h0000;
  logic        ci = 1'b0, sub = 1'b0;
  logic        iv1 = 1'b0, iv2 = 1'b0, or1 = 1'b1, or2 = 1'b1;
  logic        ir1, ir2, ov1, ov2, co1, co2, ovf1, ovf2;
  logic [15:0] s1, s2;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] last_s [2];
  vec_t tbl [10];

  always #5 clk = ~clk;

  fa_multicycle #(.WIDTH(16), .CHUNK(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(ov1), .out_ready(or1), .s(s1), .co(co1), .ovf(ovf1)
  );

  fa_multicycle #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(ov2), .out_ready(or2), .s(s2), .co(co2), .ovf(ovf2)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full transaction on one instance (sel 0: CHUNK=4, sel 1: CHUNK=16) with out_ready high
  task automatic run_op(input int sel, input vec_t v, input string nm);
    int lat;
    int exp_lat;
    exp_lat = (sel != 0) ? 1 : 4;
    chk({nm, " in_ready"}, (sel != 0) ? ir2 : ir1, 16'd1);
    a = v.a; b = v.b; ci = v.ci; sub = v.sub;
    if (sel != 0) iv2 = 1'b1; else iv1 = 1'b1;
    tick();
    iv1 = 1'b0; iv2 = 1'b0;
    a = ~v.a; b = ~v.b; ci = ~v.ci; sub = ~v.sub;
    chk({nm, " s_hold"}, (sel != 0) ? s2 : s1, last_s[sel]);
    lat = 0;
    while (!((sel != 0) ? ov2 : ov1) && lat < 40) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 16'(lat), 16'(exp_lat));
    chk({nm, " s"},   (sel != 0) ? s2 : s1, v.s);
    chk({nm, " co"},  (sel != 0) ? co2 : co1, 16'(v.co));
    chk({nm, " ovf"}, (sel != 0) ? ovf2 : ovf1, 16'(v.ovf));
    last_s[sel] = v.s;
    tick();
    chk({nm, " valid_drop"}, (sel != 0) ? ov2 : ov1, 16'd0);
  endtask

  initial begin
    int lat;
    //          a         b         ci    sub   s         co    ovf
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[9] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    last_s[0] = 16'h0000;
    last_s[1] = 16'h0000;

    // Reset for two cycles
    tick();
    chk("rst in_ready1", ir1, 16'd0);
    chk("rst in_ready2", ir2, 16'd0);
    tick();
    chk("rst in_ready1 c2", ir1, 16'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready1", ir1, 16'd1);
    chk("post-rst in_ready2", ir2, 16'd1);
    chk("post-rst out_valid", ov1, 16'd0);
    chk("post-rst s", s1, 16'h0000);
    chk("post-rst co", co1, 16'd0);
    chk("post-rst ovf", ovf1, 16'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(0, tbl[i], $sformatf("c4 v%0d", i));
      run_op(1, tbl[i], $sformatf("c16 v%0d", i));
    end

    // Backpressure: result held while out_ready low, new operands refused
    a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0;
    or1 = 1'b0; iv1 = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'h0001;
    lat = 0;
    while (!ov1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp latency", 16'(lat), 16'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp out_valid", ov1, 16'd1);
      chk("bp s", s1, 16'h2345);
      chk("bp in_ready", ir1, 16'd0);
    end
    or1 = 1'b1;
    tick();
    chk("bp release out_valid", ov1, 16'd0);
    chk("bp release in_ready", ir1, 16'd1);
    chk("bp release s", s1, 16'h2345);
    tick();
    iv1 = 1'b0;
    chk("bp next accepted", ir1, 16'd0);
    lat = 0;
    while (!ov1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp next latency", 16'(lat), 16'd4);
    chk("bp next s", s1, 16'h0000);
    chk("bp next co", co1, 16'd1);
    tick();
    last_s[0] = 16'h0000;

    // Leave a nonzero result behind, then reset in the middle of the next op
    run_op(0, tbl[5], "pre-rst");
    a = 16'h00FF; b = 16'h0001; ci = 1'b0; sub = 1'b0; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid-rst in_ready", ir1, 16'd0);
    chk("mid-rst out_valid", ov1, 16'd0);
    chk("mid-rst s", s1, 16'h0000);
    chk("mid-rst co", co1, 16'd0);
    chk("mid-rst ovf", ovf1, 16'd0);
    rst = 1'b0;
    #1;
    chk("mid-rst idle", ir1, 16'd1);
    last_s[0] = 16'h0000;
    run_op(0, '{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0}, "after-rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
